adder_pipe_n: RTL

ADDER_PIPE_N -- requirements
Module: adder_pipe_n

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_full_n.sv | 14 +
 rtl/adder_pipe_n.sv | 122 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared defaults, chunk-width helper and stage record for the pipelined chunked adder.
package adder_pkg;

   localparam int unsigned DefaultN      = 8;
   localparam int unsigned DefaultStages = 2;

   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

   // Stage record at the default width; adder_pipe_n mirrors this layout at its own width.
   typedef struct packed {
      logic                valid;
      logic                carry;
      logic [DefaultN-1:0] psum;
      logic [DefaultN-1:0] a;
      logic [DefaultN-1:0] b;
   } stage_t;

endpackage

// File: rtl/adder_full_n.sv
// Plain n-bit ripple adder with carry in/out, used as the per-stage chunk adder.
module adder_full_n #(
   parameter int unsigned n = 4
) (
   input  logic [n-1:0] X,
   input  logic [n-1:0] Y,
   input  logic         Cin,
   output logic [n-1:0] S,
   output logic         Cout
);

   assign {Cout, S} = {1'b0, X} + {1'b0, Y} + {{n{1'b0}}, Cin};

endmodule

// File: rtl/adder_pipe_n.sv
// adder_pipe_n: n-bit add/subtract split into STAGES registered chunks, valid/ready handshake.
// Define ADDER_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module adder_pipe_n
   import adder_pkg::*;
#(
   parameter int unsigned n      = DefaultN,
   parameter int unsigned STAGES = DefaultStages
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] X,
   input  logic [n-1:0] Y,
   input  logic         Cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] sum,
   output logic         carry
`ifdef ADDER_PIPE_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned W    = chunk_width(n, STAGES);
   localparam int unsigned Last = STAGES - 1;

   if (n < 2 || STAGES < 1 || STAGES > n || (n % STAGES) != 0) begin : g_bad_cfg
      $fatal(1, "adder_pipe_n: n must be >= 2 and an exact multiple of STAGES");
   end

   typedef struct packed {
      logic         valid;
      logic         carry;
      logic [n-1:0] psum;
      logic [n-1:0] a;
      logic [n-1:0] b;
   } stage_n_t;

   stage_n_t         src   [STAGES];
   stage_n_t         st_d  [STAGES];
   stage_n_t         st_q  [STAGES];
   logic [W-1:0]     chunk_sum [STAGES];
   logic [STAGES-1:0] chunk_cout;
   logic             stall;

   // Subtraction enters as X + ~Y + 1, so Cin is ignored when sub is set.
   assign src[0] = '{valid: in_valid, carry: sub | Cin, psum: '0, a: X, b: sub ? ~Y : Y};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k > 0) begin : g_link
         assign src[k] = st_q[k-1];
      end

      adder_full_n #(
         .n(W)
      ) u_chunk (
         .X    (src[k].a[k*W +: W]),
         .Y    (src[k].b[k*W +: W]),
         .Cin  (src[k].carry),
         .S    (chunk_sum[k]),
         .Cout (chunk_cout[k])
      );
   end

   assign out_valid = st_q[Last].valid;
   assign sum       = st_q[Last].psum;
   assign carry     = st_q[Last].carry;
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   // Bubbles load an all-zero record so sum reads 0 whenever nothing valid is present.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         st_d[k] = '0;
         if (stall) begin
            st_d[k] = st_q[k];
         end else if (src[k].valid) begin
            st_d[k]                = src[k];
            st_d[k].psum[k*W +: W] = chunk_sum[k];
            st_d[k].carry          = chunk_cout[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES; k++) begin
         if (rst) begin
            st_q[k] <= '0;
         end else begin
            st_q[k] <= st_d[k];
         end
      end
   end

`ifdef ADDER_PIPE_OVF_EN
   logic ovf_d, ovf_q;

   // Carry into the MSB is recovered as a ^ b ^ s at that bit.
   always_comb begin
      ovf_d = 1'b0;
      if (stall) begin
         ovf_d = ovf_q;
      end else if (src[Last].valid) begin
         ovf_d = chunk_cout[Last] ^ src[Last].a[n-1] ^ src[Last].b[n-1] ^ chunk_sum[Last][W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
